alarm_controller: RTL and testbench

//  Alarm stage downstream of the real-time clock counters.
//  - Holds an HH:MM alarm setpoint, loaded as BCD from the switches.
//  - Compares the setpoint against the running HOURS/MINUTES/SECONDS once per second.
//  - Runs an arm/ring/snooze state machine and drives the alarm indicators.

---
 rtl/alarm_controller.sv | 151 +++++++++++++++
 tb/tb_alarm_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm stage: BCD setpoint entry, per-second HH:MM match, arm/ring/snooze FSM.
// Optional macro ALARM_BLINK_EN: Ring_led blinks once per Tick while ringing.
module alarm_controller #(
  parameter int unsigned DEF_HH     = 6,
  parameter int unsigned DEF_MM     = 0,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick,
  input  logic [4:0] Hours,
  input  logic [5:0] Minutes,
  input  logic [5:0] Seconds,
  input  logic [7:0] Bcd_in,
  input  logic       Load_hh,
  input  logic       Load_mm,
  input  logic       Arm,
  input  logic       Snooze,
  input  logic       Dismiss,
  output logic [4:0] Alarm_hh,
  output logic [5:0] Alarm_mm,
  output logic       Armed,
  output logic       Ringing,
  output logic       Snoozing,
  output logic       Ring_led,
  output logic       Load_err
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_e;

  localparam logic [7:0] RING_LAST   = 8'(RING_SEC - 1);
  localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SEC - 1);

  state_e     state_q, state_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic [9:0] snz_cnt_q, snz_cnt_d;
  logic [4:0] alarm_hh_q, alarm_hh_d;
  logic [5:0] alarm_mm_q, alarm_mm_d;
  logic       load_err_q, load_err_d;

  logic [7:0] bcd_val;
  logic       bcd_bad_digit;
  logic       hh_rej;
  logic       mm_rej;
  logic       match;

  always_comb begin
    bcd_val       = ({4'd0, Bcd_in[7:4]} * 8'd10) + {4'd0, Bcd_in[3:0]};
    bcd_bad_digit = (Bcd_in[7:4] > 4'd9) || (Bcd_in[3:0] > 4'd9);
    hh_rej        = bcd_bad_digit || (bcd_val > 8'd23);
    mm_rej        = bcd_bad_digit || (bcd_val > 8'd59);
    alarm_hh_d    = (Load_hh && !hh_rej) ? bcd_val[4:0] : alarm_hh_q;
    alarm_mm_d    = (Load_mm && !mm_rej) ? bcd_val[5:0] : alarm_mm_q;
    load_err_d    = (Load_hh && hh_rej) || (Load_mm && mm_rej);
  end

  // Compares against the stored setpoint, so a load in the same cycle applies from the next Tick.
  assign match = Tick && (Seconds == 6'd0) && (Hours == alarm_hh_q) && (Minutes == alarm_mm_q);

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = '0;
    snz_cnt_d  = '0;
    if (!Arm) begin
      state_d = DISARMED;
    end else begin
      case (state_q)
        DISARMED: state_d = ARMED;
        ARMED:    if (match) state_d = RINGING;
        RINGING: begin
          if (Dismiss) begin
            state_d = ARMED;
          end else if (Snooze) begin
            state_d = SNOOZE;
          end else if (Tick) begin
            if (ring_cnt_q == RING_LAST) state_d = ARMED;
            else ring_cnt_d = ring_cnt_q + 8'd1;
          end else begin
            ring_cnt_d = ring_cnt_q;
          end
        end
        SNOOZE: begin
          if (Dismiss) begin
            state_d = ARMED;
          end else if (Tick) begin
            if (snz_cnt_q == SNOOZE_LAST) state_d = RINGING;
            else snz_cnt_d = snz_cnt_q + 10'd1;
          end else begin
            snz_cnt_d = snz_cnt_q;
          end
        end
        default: state_d = DISARMED;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= DISARMED;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      alarm_hh_q <= 5'(DEF_HH);
      alarm_mm_q <= 6'(DEF_MM);
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      alarm_hh_q <= alarm_hh_d;
      alarm_mm_q <= alarm_mm_d;
      load_err_q <= load_err_d;
    end
  end

  assign Alarm_hh = alarm_hh_q;
  assign Alarm_mm = alarm_mm_q;
  assign Armed    = (state_q != DISARMED);
  assign Ringing  = (state_q == RINGING);
  assign Snoozing = (state_q == SNOOZE);
  assign Load_err = load_err_q;

`ifdef ALARM_BLINK_EN
  logic led_q, led_d;

  // Forced to 1 on entry into RINGING, then toggled per Tick; 0 outside RINGING.
  always_comb begin
    led_d = 1'b0;
    if (state_d == RINGING) begin
      if (state_q != RINGING) led_d = 1'b1;
      else if (Tick)          led_d = ~led_q;
      else                    led_d = led_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) led_q <= 1'b0;
    else     led_q <= led_d;
  end

  assign Ring_led = led_q;
`else
  assign Ring_led = Ringing;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios plus random stimulus vs. a countdown model.
module tb_alarm_controller;

  localparam int DEF_HH     = 6;
  localparam int DEF_MM     = 0;
  localparam int RING_SEC   = 60;
  localparam int SNOOZE_SEC = 300;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Tick = 1'b0;
  logic [4:0] Hours = '0;
  logic [5:0] Minutes = '0;
  logic [5:0] Seconds = '0;
  logic [7:0] Bcd_in = '0;
  logic       Load_hh = 1'b0;
  logic       Load_mm = 1'b0;
  logic       Arm = 1'b0;
  logic       Snooze = 1'b0;
  logic       Dismiss = 1'b0;
  logic [4:0] Alarm_hh;
  logic [5:0] Alarm_mm;
  logic       Armed, Ringing, Snoozing, Ring_led, Load_err;

  alarm_controller #(
    .DEF_HH    (DEF_HH),
    .DEF_MM    (DEF_MM),
    .RING_SEC  (RING_SEC),
    .SNOOZE_SEC(SNOOZE_SEC)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Tick    (Tick),
    .Hours   (Hours),
    .Minutes (Minutes),
    .Seconds (Seconds),
    .Bcd_in  (Bcd_in),
    .Load_hh (Load_hh),
    .Load_mm (Load_mm),
    .Arm     (Arm),
    .Snooze  (Snooze),
    .Dismiss (Dismiss),
    .Alarm_hh(Alarm_hh),
    .Alarm_mm(Alarm_mm),
    .Armed   (Armed),
    .Ringing (Ringing),
    .Snoozing(Snoozing),
    .Ring_led(Ring_led),
    .Load_err(Load_err)
  );

  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: enabled flag plus countdowns of Ticks left to ring / snooze.
  int m_hh, m_mm;
  bit m_en;
  int m_ring_left, m_snz_left;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int conv(input logic [7:0] b, input int lim);
    int t, u, v;
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    v = t * 10 + u;
    if (t > 9 || u > 9 || v > lim) return -1;
    return v;
  endfunction

  task automatic model_step();
    int vh, vm;
    vh = conv(Bcd_in, 23);
    vm = conv(Bcd_in, 59);
    if (Rst) begin
      m_hh = DEF_HH; m_mm = DEF_MM; m_en = 0;
      m_ring_left = 0; m_snz_left = 0; m_err = 0;
      return;
    end
    m_err = (Load_hh && vh < 0) || (Load_mm && vm < 0);
    if (!Arm) begin
      m_en = 0; m_ring_left = 0; m_snz_left = 0;
    end else if (!m_en) begin
      m_en = 1;
    end else if (m_ring_left > 0) begin
      if (Dismiss) m_ring_left = 0;
      else if (Snooze) begin m_ring_left = 0; m_snz_left = SNOOZE_SEC; end
      else if (Tick) m_ring_left--;
    end else if (m_snz_left > 0) begin
      if (Dismiss) m_snz_left = 0;
      else if (Tick) begin
        m_snz_left--;
        if (m_snz_left == 0) m_ring_left = RING_SEC;
      end
    end else if (Tick && Seconds == 0 && int'(Hours) == m_hh && int'(Minutes) == m_mm) begin
      m_ring_left = RING_SEC;
    end
    if (Load_hh && vh >= 0) m_hh = vh;
    if (Load_mm && vm >= 0) m_mm = vm;
  endtask

  task automatic step();
    logic exp_led;
    model_step();
    @(posedge Clk);
    #1;
`ifdef ALARM_BLINK_EN
    exp_led = (m_ring_left > 0) && (((RING_SEC - m_ring_left) % 2) == 0);
`else
    exp_led = (m_ring_left > 0);
`endif
    check("alarm_hh", 32'(Alarm_hh), 32'(m_hh));
    check("alarm_mm", 32'(Alarm_mm), 32'(m_mm));
    check("armed",    32'(Armed),    32'(m_en));
    check("ringing",  32'(Ringing),  32'(m_ring_left > 0));
    check("snoozing", 32'(Snoozing), 32'(m_snz_left > 0));
    check("ring_led", 32'(Ring_led), 32'(exp_led));
    check("load_err", 32'(Load_err), 32'(m_err));
    Rst = 0; Tick = 0; Load_hh = 0; Load_mm = 0; Snooze = 0; Dismiss = 0;
  endtask

  task automatic tick_at(input int h, input int m, input int s);
    Hours = 5'(h); Minutes = 6'(m); Seconds = 6'(s); Tick = 1;
    step();
  endtask

  initial begin
    m_hh = DEF_HH; m_mm = DEF_MM; m_en = 0; m_ring_left = 0; m_snz_left = 0; m_err = 0;

    // 1: reset, load 07:30, arm, match
    Rst = 1; step();
    check("rst_hh", 32'(Alarm_hh), 32'd6);
    check("rst_armed", 32'(Armed), 32'd0);
    check("rst_led", 32'(Ring_led), 32'd0);
    Bcd_in = 8'h07; Load_hh = 1; step();
    Bcd_in = 8'h30; Load_mm = 1; step();
    Arm = 1; step();
    check("t1_armed", 32'(Armed), 32'd1);
    tick_at(7, 30, 0);
    check("t1_hh", 32'(Alarm_hh), 32'd7);
    check("t1_mm", 32'(Alarm_mm), 32'd30);
    check("t1_ring", 32'(Ringing), 32'd1);

    // 2: auto-stop after RING_SEC Ticks
    for (int i = 0; i < RING_SEC - 1; i++) tick_at(7, 30, 5 + (i % 50));
    check("t2_still", 32'(Ringing), 32'd1);
    tick_at(7, 31, 0);
    check("t2_stop", 32'(Ringing), 32'd0);
    check("t2_armed", 32'(Armed), 32'd1);

    // 3: snooze and re-ring, then dismiss
    tick_at(7, 30, 0);
    Snooze = 1; step();
    check("t3_snz", 32'(Snoozing), 32'd1);
    for (int i = 0; i < SNOOZE_SEC - 1; i++) tick_at(7, 30, 0);
    check("t3_snz_end", 32'(Snoozing), 32'd1);
    tick_at(7, 36, 0);
    check("t3_rering", 32'(Ringing), 32'd1);
    Dismiss = 1; step();
    check("t3_dis_ring", 32'(Ringing), 32'd0);
    check("t3_dis_armed", 32'(Armed), 32'd1);

    // 4: rejected hour loads
    Bcd_in = 8'h24; Load_hh = 1; step();
    check("t4_err24", 32'(Load_err), 32'd1);
    check("t4_hh24", 32'(Alarm_hh), 32'd7);
    step();
    check("t4_err_clr", 32'(Load_err), 32'd0);
    Bcd_in = 8'h1A; Load_hh = 1; step();
    check("t4_err1a", 32'(Load_err), 32'd1);
    check("t4_hh1a", 32'(Alarm_hh), 32'd7);
    step();

    // 5: Dismiss beats Snooze; Arm drop mid-snooze
    tick_at(7, 30, 0);
    Dismiss = 1; Snooze = 1; step();
    check("t5_prio_armed", 32'(Armed), 32'd1);
    check("t5_prio_snz", 32'(Snoozing), 32'd0);
    tick_at(7, 30, 0);
    Snooze = 1; step();
    Arm = 0; step();
    check("t5_disarm", 32'(Armed), 32'd0);
    tick_at(7, 30, 0);
    check("t5_no_ring", 32'(Ringing), 32'd0);
    Arm = 1; step();

    // 6: reset mid-ring
    tick_at(7, 30, 0);
    check("t6_ring", 32'(Ringing), 32'd1);
    Rst = 1; step();
    check("t6_ring0", 32'(Ringing), 32'd0);
    check("t6_armed0", 32'(Armed), 32'd0);
    check("t6_hh", 32'(Alarm_hh), 32'd6);

    // Random phase, time inputs biased toward the current setpoint
    for (int c = 0; c < 6000; c++) begin
      Tick    = ($urandom % 3) == 0;
      Seconds = ($urandom % 2) ? 6'd0 : 6'($urandom_range(1, 59));
      Hours   = ($urandom % 2) ? 5'(m_hh) : 5'($urandom_range(0, 23));
      Minutes = ($urandom % 2) ? 6'(m_mm) : 6'($urandom_range(0, 59));
      Snooze  = ($urandom % 20) == 0;
      Dismiss = ($urandom % 40) == 0;
      if (Arm) Arm = ($urandom % 60) != 0;
      else     Arm = ($urandom % 3) == 0;
      Load_hh = ($urandom % 30) == 0;
      Load_mm = ($urandom % 30) == 0;
      if ($urandom % 2) Bcd_in = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
      else              Bcd_in = 8'($urandom);
      Rst = ($urandom % 500) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
